instruction_memory_loadable: RTL
================================

Name: instruction_memory_loadable

Overview:
- Parametrised, loadable instruction memory for the single-cycle and upcoming pipelined processors.
- A sequential program port fills the memory from word 0 at boot. This removes hard-coded program images from RTL.
- After loading, a fetch port serves byte-addressed, word-aligned instruction reads with one-cycle registered latency.
- Out-of-range and misaligned fetches are flagged and return a NOP word.

Parameters:
INSTR_WIDTH, 22, instruction word width in bits
ADDR_WIDTH, 22, fetch byte-address width
DEPTH, 128, number of instruction words; must be a power of two, at least 2, and at most 2^(ADDR_WIDTH-2)
NOP_WORD, 22'h268000, word returned on faulting fetch (MOVER R0, #0)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
prog_start  in  1  pulse: restart loading from word 0
prog_valid  in  1  program word present
prog_data  in  INSTR_WIDTH  program word
prog_last  in  1  marks final program word
prog_ready  out  1  memory accepts a program word
load_done  out  1  image loaded; fetch enabled
loaded_words  out  $clog2(DEPTH)+1  number of valid words
fetch_req  in  1  fetch request
fetch_addr  in  ADDR_WIDTH  byte address (PC)
fetch_valid  out  1  response valid
fetch_instr  out  INSTR_WIDTH  fetched instruction
fetch_fault  out  1  response is a fault (NOP substituted)

Behaviour:
- Reset (rst high at an edge) sets the following registered state:
  - state = LOAD, wr_ptr = 0, loaded_words = 0, load_done = 0.
  - fetch_valid = 0, fetch_instr = 0, fetch_fault = 0.
  - Memory contents are not cleared.
- prog_ready = (state == LOAD) && !rst. It is combinational, so it is 0 while reset is high.
- States:
  - LOAD: accepts program words.
  - RUN: serves fetches.
  - LOAD -> RUN on acceptance (prog_valid && prog_ready) of a word with prog_last = 1, or of the word at wr_ptr = DEPTH-1.
  - RUN -> LOAD on prog_start. This sets wr_ptr = 0, loaded_words = 0 and load_done = 0 at that edge.
  - prog_start in LOAD also sets wr_ptr = 0, and takes priority over a simultaneous write.
- Accepted write: mem[wr_ptr] <= prog_data; wr_ptr increments. On the terminating write, loaded_words <= wr_ptr+1 and load_done <= 1 at the same edge.
- Fetch request handling:
  - A fetch_req sampled in RUN produces a response exactly 1 cycle later: fetch_valid = 1 for one cycle.
  - Requests on consecutive cycles give back-to-back responses, one per cycle. There is no back-pressure.
- Fetch response contents:
  - The word index is fetch_addr[ADDR_WIDTH-1:2].
  - If fetch_addr[1:0] == 0 and index < loaded_words: fetch_instr = mem[index], fetch_fault = 0.
  - Otherwise: fetch_instr = NOP_WORD, fetch_fault = 1.
- fetch_instr and fetch_fault hold their last values when fetch_valid = 0.
- fetch_req in LOAD is ignored: no response and no fault.
- prog_start and fetch_req in the same RUN cycle: prog_start wins and the fetch is dropped (fetch_valid = 0 next cycle).
- A fetch accepted in the cycle before prog_start still returns its response, using the pre-reload image.
- Reset mid-load abandons the partial image: loaded_words = 0 and loading restarts at word 0.
- wr_ptr never wraps; the DEPTH-1 write forces RUN.
- All arithmetic is unsigned.
- The index compare must use the full-width index, so high address bits beyond DEPTH fault rather than alias.

Decomposition:
- Package instr_mem_pkg holds:
  - typedef enum logic {LOAD, RUN} imem_state_t
  - localparam INSTR_WIDTH_DEF = 22 and the NOP_WORD default
  - function is_aligned(addr)
- Sub-module imem_array: single write port, single registered read port, synchronous, inferable as block RAM.
- The top level holds the FSM, write pointer, range/alignment check and fault muxing. The fault decision is registered alongside the read.

Test Plan:
- Load: reset, then 13 words 22'h268000..22'h26800C with prog_last on the 13th. Required:
  - prog_ready is 1 throughout.
  - load_done rises at the edge accepting word 13.
  - loaded_words = 13; prog_ready = 0 afterwards.
- Fetch:
  - fetch_addr = 0x08 -> next cycle fetch_valid = 1, fetch_instr = 22'h268002, fetch_fault = 0.
  - Back-to-back requests to 0x00, 0x04, 0x30 -> responses 22'h268000, 22'h268001, 22'h26800C on consecutive cycles.
- Faults:
  - fetch_addr = 0x34 (index 13) -> NOP_WORD, fault = 1.
  - fetch_addr = 0x06 -> NOP_WORD, fault = 1.
  - fetch_addr = 0x200 with DEPTH = 128 -> fault = 1.
- Reload:
  - In RUN, assert prog_start and fetch_req together -> no response; load_done = 0.
  - Load 2 words 22'h3FFFFF, 22'h000001 -> loaded_words = 2; fetch 0x08 faults.
- Full depth, DEPTH = 4: write 4 words without prog_last -> RUN after the 4th; loaded_words = 4; a 5th prog_valid is not accepted.
- Reset mid-load: after 3 words, pulse rst -> loaded_words = 0, load_done = 0. A fetch after reset produces no response until a new load completes.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared types, defaults and helpers for the loadable instruction memory
package instr_mem_pkg;
    typedef enum logic {LOAD, RUN} imem_state_t;
    localparam int INSTR_WIDTH_DEF = 22;
    localparam logic [INSTR_WIDTH_DEF-1:0] NOP_WORD_DEF = 22'h268000;
    function automatic logic is_aligned(input logic [1:0] addr);
        return addr == 2'b00;
    endfunction
endpackage

// File: rtl/imem_array.sv
// imem_array: single write port, single registered read port, block-RAM inferable storage
module imem_array #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/instruction_memory_loadable.sv
// instruction_memory_loadable: boot-loaded instruction memory with registered, fault-checked fetch port
module instruction_memory_loadable
    import instr_mem_pkg::*;
#(
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int ADDR_WIDTH = 22,
    parameter int DEPTH = 128,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD = INSTR_WIDTH'(NOP_WORD_DEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_start,
    input  logic                     prog_valid,
    input  logic [INSTR_WIDTH-1:0]   prog_data,
    input  logic                     prog_last,
    output logic                     prog_ready,
    output logic                     load_done,
    output logic [$clog2(DEPTH):0]   loaded_words,
    input  logic                     fetch_req,
    input  logic [ADDR_WIDTH-1:0]    fetch_addr,
    output logic                     fetch_valid,
    output logic [INSTR_WIDTH-1:0]   fetch_instr,
    output logic                     fetch_fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int CW = AW + 1;
    localparam int MW = IW > CW ? IW : CW;
    imem_state_t state, next_state;
    logic [AW-1:0] wr_ptr;
    logic [IW-1:0] index;
    logic [INSTR_WIDTH-1:0] rdata;
    logic accept, last, fetch_go, in_range, has_data;
    assign prog_ready = state == LOAD && !rst;
    assign accept = prog_valid && prog_ready && !prog_start;
    assign last = accept && (prog_last || wr_ptr == AW'(DEPTH - 1));
    assign fetch_go = fetch_req && state == RUN && !prog_start;
    assign index = fetch_addr[ADDR_WIDTH-1:2];
    assign in_range = MW'(index) < MW'(loaded_words);
    assign fetch_instr = !has_data ? '0 : fetch_fault ? NOP_WORD : rdata;
    always_comb begin
        next_state = state == LOAD ? (last ? RUN : LOAD) : (prog_start ? LOAD : RUN);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOAD;
            wr_ptr       <= '0;
            loaded_words <= '0;
            load_done    <= 1'b0;
            fetch_valid  <= 1'b0;
            fetch_fault  <= 1'b0;
            has_data     <= 1'b0;
        end else begin
            state       <= next_state;
            fetch_valid <= fetch_go;
            if (fetch_go) begin
                fetch_fault <= !(is_aligned(fetch_addr[1:0]) && in_range);
                has_data    <= 1'b1;
            end
            if (prog_start) begin
                wr_ptr       <= '0;
                loaded_words <= '0;
                load_done    <= 1'b0;
            end else if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (last) begin
                    loaded_words <= CW'(wr_ptr) + CW'(1);
                    load_done    <= 1'b1;
                end
            end
        end
    end
    imem_array #(.WIDTH(INSTR_WIDTH), .DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (prog_data),
        .re    (fetch_go),
        .raddr (index[AW-1:0]),
        .rdata (rdata)
    );
endmodule
